// File: rtl/dcache_port_arbiter_pkg.sv
// dcache_port_arbiter_pkg
// Purpose: shared definitions for the data-cache port arbiter. Holds the
//          global width/size/tag macros used by the memory pipeline and
//          the arbiter FSM state encoding.
// Contents:
//   `WORD_SIZE, `ADDRESS_WIDTH, `SIZE_WRITE_WIDTH, `ROB_ENTRY_WIDTH  widths
//   `FULL_WORD_SIZE, `BYTE_SIZE                                      size codes
//   `ROB_INVALID_ENTRY                                               empty tag
//   arbState_t                                                       FSM states

`ifndef DCACHE_PORT_ARBITER_DEFINES
`define DCACHE_PORT_ARBITER_DEFINES
`define WORD_SIZE          32
`define ADDRESS_WIDTH      32
`define SIZE_WRITE_WIDTH   2
`define ROB_ENTRY_WIDTH    6
`define FULL_WORD_SIZE     2'b10
`define BYTE_SIZE          2'b00
`define ROB_INVALID_ENTRY  {`ROB_ENTRY_WIDTH{1'b1}}
`endif

package dcache_port_arbiter_pkg;

  // One outstanding cache operation at a time; SQUASH drains a killed load.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD_WAIT   = 2'd1,
    ST_STORE_WAIT  = 2'd2,
    ST_LOAD_SQUASH = 2'd3
  } arbState_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Purpose: shares the single data-cache port between memory-stage loads
//          and store-buffer drain writes. Issues one request, waits for the
//          cache response, then reports load_done or store_success.
//          Stores win when the buffer is full or after STARVE_LIMIT load
//          grants made while a store was waiting. Flush kills loads only.
// Ports:
//   clk, rst (async, active-low)
//   load_*      load request from the memory stage, grant/stall/done back
//   sb_*        store-buffer head, store_success pops it
//   flush       pipeline flush
//   cache_*     request/response handshake with the data cache

module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE        = `WORD_SIZE,
  parameter int WIDTH            = `ADDRESS_WIDTH,
  parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
  parameter int ROB_ENTRY_WIDTH  = `ROB_ENTRY_WIDTH,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_req,
  input  logic [WIDTH-1:0]            load_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] load_size,
  input  logic [ROB_ENTRY_WIDTH-1:0]  load_rob_id,
  output logic                        load_grant,
  output logic                        load_stall,
  output logic                        load_done,
  output logic [WORD_SIZE-1:0]        load_value,
  output logic [ROB_ENTRY_WIDTH-1:0]  load_done_rob_id,
  input  logic                        sb_wenable,
  input  logic [WIDTH-1:0]            sb_addr,
  input  logic [WORD_SIZE-1:0]        sb_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
  input  logic                        sb_full,
  output logic                        store_success,
  input  logic                        flush,
  output logic                        cache_req,
  output logic                        cache_we,
  output logic [WIDTH-1:0]            cache_addr,
  output logic [WORD_SIZE-1:0]        cache_wdata,
  output logic [SIZE_WRITE_WIDTH-1:0] cache_size,
  input  logic                        cache_ready,
  input  logic                        cache_resp_valid,
  input  logic [WORD_SIZE-1:0]        cache_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arbState_t                  r_state;
  arbState_t                  w_nextState;
  logic [CNT_W-1:0]           r_starveCnt;
  logic [ROB_ENTRY_WIDTH-1:0] r_robTag;
  logic                       w_storeWins;
  logic                       w_loadWins;
  logic                       w_loadGrant;
  logic                       w_storeGrant;

  // Arbitration only happens in IDLE. A flush forces a pending store to
  // win, because the competing load is being killed anyway.
  always_comb begin
    w_storeWins = 1'b0;
    w_loadWins  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_storeWins = sb_wenable &&
                    (sb_full || (r_starveCnt >= CNT_MAX) || !load_req || flush);
      w_loadWins  = !w_storeWins && load_req && !flush;
    end
    w_loadGrant  = w_loadWins && cache_ready;
    w_storeGrant = w_storeWins && cache_ready;
  end

  // Next state and all outputs. The final block forces every output to 0
  // while reset is held, including the purely combinational request path.
  always_comb begin
    w_nextState      = r_state;
    cache_req        = 1'b0;
    cache_we         = 1'b0;
    cache_addr       = '0;
    cache_wdata      = '0;
    cache_size       = '0;
    load_grant       = 1'b0;
    load_done        = 1'b0;
    load_value       = '0;
    load_done_rob_id = '0;
    store_success    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        cache_req  = w_storeWins || w_loadWins;
        load_grant = w_loadGrant;
        if (w_storeWins) begin
          cache_we    = 1'b1;
          cache_addr  = sb_addr;
          cache_wdata = sb_value;
          cache_size  = sb_size;
        end else if (w_loadWins) begin
          cache_addr = load_addr;
          cache_size = load_size;
        end
        if (w_storeGrant) begin
          w_nextState = ST_STORE_WAIT;
        end else if (w_loadGrant) begin
          w_nextState = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (cache_resp_valid) begin
          // A flush in the response cycle still retires the cache access
          // but must not deliver the data.
          if (!flush) begin
            load_done        = 1'b1;
            load_value       = cache_rdata;
            load_done_rob_id = r_robTag;
          end
          w_nextState = ST_IDLE;
        end else if (flush) begin
          w_nextState = ST_LOAD_SQUASH;
        end
      end
      ST_STORE_WAIT: begin
        if (cache_resp_valid) begin
          store_success = 1'b1;
          w_nextState   = ST_IDLE;
        end
      end
      ST_LOAD_SQUASH: begin
        if (cache_resp_valid) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase

    load_stall = load_req && !load_grant;

    if (!rst) begin
      cache_req        = 1'b0;
      cache_we         = 1'b0;
      cache_addr       = '0;
      cache_wdata      = '0;
      cache_size       = '0;
      load_grant       = 1'b0;
      load_stall       = 1'b0;
      load_done        = 1'b0;
      load_value       = '0;
      load_done_rob_id = '0;
      store_success    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Anti-starvation counter: counts load grants that bypassed a waiting
  // store, cleared whenever a store gets the port. The ROB tag travels with
  // the load so it can be returned on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starveCnt <= '0;
      r_robTag    <= ROB_ENTRY_WIDTH'(`ROB_INVALID_ENTRY);
    end else begin
      if (w_storeGrant) begin
        r_starveCnt <= '0;
      end else if (w_loadGrant && sb_wenable && (r_starveCnt < CNT_MAX)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
      if (w_loadGrant) begin
        r_robTag <= load_rob_id;
      end
    end
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Sequences the single data-cache port between memory-stage loads and store-buffer drain writes.
- Grants one operation at a time, waits for the cache response, then returns store_success to the store buffer or load_done to the pipeline.
- Enforces store anti-starvation and gives stores priority when the store buffer is full.
- Squashes an in-flight load on pipeline flush. Committed stores are never dropped.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): data width.
- WIDTH, `ADDRESS_WIDTH (32): physical address width.
- SIZE_WRITE_WIDTH, `SIZE_WRITE_WIDTH: access size code width.
- ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH: ROB tag width.
- STARVE_LIMIT, 4: number of consecutive load grants allowed while a store is pending; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock domain; asynchronous, active-low (asserted when 0).
- load_req  in  1  memory stage requests a load.
- load_addr  in  WIDTH  load physical address.
- load_size  in  SIZE_WRITE_WIDTH  `FULL_WORD_SIZE or `BYTE_SIZE.
- load_rob_id  in  ROB_ENTRY_WIDTH  tag of the requesting load.
- load_grant  out  1  load accepted by the cache this cycle.
- load_stall  out  1  load_req && !load_grant.
- load_done  out  1  load data valid this cycle.
- load_value  out  WORD_SIZE  load data.
- load_done_rob_id  out  ROB_ENTRY_WIDTH  tag of the completing load.
- sb_wenable  in  1  store-buffer head is ready to write (SB cache_wenable).
- sb_addr  in  WIDTH  store-buffer head address.
- sb_value  in  WORD_SIZE  store-buffer head data.
- sb_size  in  SIZE_WRITE_WIDTH  store-buffer head size.
- sb_full  in  1  store buffer is full.
- store_success  out  1  one-cycle pulse; the store buffer pops its head on this edge.
- flush  in  1  pipeline flush; kills the pending or in-flight load.
- cache_req  out  1  request valid to the cache.
- cache_we  out  1  1 = write, 0 = read.
- cache_addr  out  WIDTH  request address.
- cache_wdata  out  WORD_SIZE  write data.
- cache_size  out  SIZE_WRITE_WIDTH  access size.
- cache_ready  in  1  cache accepts the request this cycle.
- cache_resp_valid  in  1  cache completes the accepted request.
- cache_rdata  in  WORD_SIZE  read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, starve_cnt=0, tag register=`ROB_INVALID_ENTRY.
  - All outputs 0 while rst=0.
- States: IDLE, LOAD_WAIT, STORE_WAIT, LOAD_SQUASH. At most one outstanding request.
- IDLE arbitration (combinational):
  - Store wins if sb_wenable && (sb_full || starve_cnt>=STARVE_LIMIT || !load_req || flush).
  - Otherwise a load wins if load_req && !flush.
- IDLE request outputs:
  - cache_req=1 when there is a winner; cache_we/addr/wdata/size are taken from the winner.
  - cache_wdata=0 for loads.
- Grant and transitions:
  - Grant occurs when cache_ready=1. load_grant mirrors a load grant.
  - Load grant: latch load_rob_id, go to LOAD_WAIT.
  - Store grant: go to STORE_WAIT, starve_cnt<=0.
  - starve_cnt increments (saturating at STARVE_LIMIT) on a load grant while sb_wenable=1.
- WAIT states:
  - cache_req=0 in every non-IDLE state.
  - LOAD_WAIT with cache_resp_valid: load_done=1, load_value=cache_rdata, load_done_rob_id=latched tag; go to IDLE.
  - STORE_WAIT with cache_resp_valid: store_success=1; go to IDLE.
  - No new grant in the response cycle, so the minimum spacing between operations is 2 cycles.
- Flush:
  - flush in LOAD_WAIT (including the response cycle): load_done suppressed.
  - If no response that cycle, go to LOAD_SQUASH; LOAD_SQUASH waits for cache_resp_valid and discards it, then goes to IDLE.
  - flush in STORE_WAIT has no effect.
  - flush in IDLE blocks load grant only.
- A cache_resp_valid received in IDLE is ignored; no outputs change.
- Reset asserted mid-operation returns the FSM to IDLE. The cache is reset by the same signal, so no orphan response is expected.
- Widths: starve_cnt is $clog2(STARVE_LIMIT+1) bits and saturates.

Decomposition:
- Shared package/defines:
  - state encoding (4 states, 2 bits);
  - `FULL_WORD_SIZE, `BYTE_SIZE, `ROB_INVALID_ENTRY, `SIZE_WRITE_WIDTH.
- Single module. The arbitration decision is small enough to stay inline; no sub-module.

Test Plan:
- Lone load:
  - load_req=1, addr=0x100, rob=5, cache_ready=1, resp 3 cycles later with rdata=0xDEADBEEF.
  - Expect load_grant in cycle 0, then load_done with value 0xDEADBEEF and rob 5 in cycle 3.
- Lone store:
  - sb_wenable=1, addr=0x200, value=0x11, resp after 2 cycles.
  - Expect cache_we=1 and exactly one store_success pulse; the next IDLE cycle regrants if sb_wenable is still 1.
- Starvation:
  - load_req and sb_wenable held at 1, STARVE_LIMIT=4, immediate ready/resp.
  - Expect grant order L,L,L,L,S, repeating.
- sb_full priority:
  - load_req=1, sb_wenable=1, sb_full=1.
  - Expect a store grant first and load_stall=1.
- Flush mid-load:
  - Load granted, flush asserted 1 cycle later, resp 2 cycles later.
  - Expect load_done never asserted, FSM back in IDLE after the resp, next store granted normally.
- Async reset:
  - Drop rst in STORE_WAIT between clock edges.
  - Expect all outputs 0 immediately, state IDLE, no store_success after release.
